// File: rtl/sync_down_counter_pkg.sv
// Shared definitions for sync_down_counter: the FSM state encoding and the default counter width.
package sync_down_counter_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sync_down_counter.sv
// Synchronous down counter with parallel load, a registered terminal-count pulse, and auto-reload or one-shot wrap.
// Optional sticky underflow flag enabled by defining SYNC_DOWN_COUNTER_UFLOW_EN.
module sync_down_counter
  import sync_down_counter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int AUTO_RELOAD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             T,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy,
  output logic             uflow
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_reg,  state_next;
  logic [WIDTH-1:0] count_reg,  count_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             tc_reg,     tc_next;
  logic             busy_reg;

  // Load outranks counting; the wrap is decided by out==0, never by modulo underflow.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    reload_next = reload_reg;
    tc_next     = 1'b0;
    if (load) begin
      count_next  = load_val;
      reload_next = load_val;
      state_next  = RUN;
    end else if (state_reg == RUN && T) begin
      if (count_reg != '0) begin
        count_next = count_reg - ONE;
      end else begin
        tc_next = 1'b1;
        if (AUTO_RELOAD != 0) begin
          count_next = reload_reg;
        end else begin
          count_next = '0;
          state_next = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      reload_reg <= '0;
      tc_reg     <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      reload_reg <= reload_next;
      tc_reg     <= tc_next;
      busy_reg   <= (state_next == RUN);
    end
  end

  assign out  = count_reg;
  assign tc   = tc_reg;
  assign busy = busy_reg;

`ifdef SYNC_DOWN_COUNTER_UFLOW_EN
  logic uflow_reg;

  // A load on the same edge as a set condition wins and clears the flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      uflow_reg <= 1'b0;
    end else if (load) begin
      uflow_reg <= 1'b0;
    end else if (tc_next) begin
      uflow_reg <= 1'b1;
    end
  end

  assign uflow = uflow_reg;
`else
  assign uflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed bench for sync_down_counter: one auto-reload and one one-shot instance sharing stimulus.
module tb_sync_down_counter;
  import sync_down_counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       T = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;
  logic [2:0] out_a, out_b;
  logic       tc_a, tc_b, busy_a, busy_b, uflow_a, uflow_b;

  int checks = 0;
  int failures = 0;

`ifdef SYNC_DOWN_COUNTER_UFLOW_EN
  localparam logic UF = 1'b1;
`else
  localparam logic UF = 1'b0;
`endif

  // Expected outputs of the auto-reload instance after each T=1 edge following load of 5.
  logic [2:0] auto_out [7] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5, 3'd4};
  logic       auto_tc  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  always #10 clk = ~clk;

  sync_down_counter #(.WIDTH(3), .AUTO_RELOAD(1)) dut_a (
    .clk(clk), .rst(rst), .T(T), .load(load), .load_val(load_val),
    .out(out_a), .tc(tc_a), .busy(busy_a), .uflow(uflow_a)
  );

  sync_down_counter #(.WIDTH(3), .AUTO_RELOAD(0)) dut_b (
    .clk(clk), .rst(rst), .T(T), .load(load), .load_val(load_val),
    .out(out_b), .tc(tc_b), .busy(busy_b), .uflow(uflow_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, then T without load must leave the counter idle.
    tick();
    rst = 1'b1;
    check("rst_out", out_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_tc", tc_a, 0);
    check("rst_uflow", uflow_a, 0);
    T = 1'b1;
    tick();
    tick();
    check("idle_T_out", out_a, 0);
    check("idle_T_busy", busy_a, 0);
    check("idle_T_tc", tc_a, 0);

    // Auto-reload: load 5, count through one wrap.
    T = 1'b0; load = 1'b1; load_val = 3'd5;
    tick();
    load = 1'b0; T = 1'b1;
    check("auto_load_out", out_a, 5);
    check("auto_load_busy", busy_a, 1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("auto_out[%0d]", i), out_a, auto_out[i]);
      check($sformatf("auto_tc[%0d]", i), tc_a, auto_tc[i]);
      check($sformatf("auto_uflow[%0d]", i), uflow_a, (i >= 5) ? UF : 1'b0);
    end
    // Second wrap: 4 -> 3,2,1,0,5; flag stays set.
    for (int i = 0; i < 5; i++) tick();
    check("wrap2_out", out_a, 5);
    check("wrap2_tc", tc_a, 1);
    check("wrap2_uflow", uflow_a, UF);
    check("wrap2_busy", busy_a, 1);

    // Load clears the sticky flag.
    load = 1'b1; load_val = 3'd4;
    tick();
    load = 1'b0;
    check("reload4_out", out_a, 4);
    check("reload4_uflow", uflow_a, 0);
    check("reload4_tc", tc_a, 0);

    // Load coinciding with the wrap edge takes the load.
    for (int i = 0; i < 4; i++) tick();
    check("pre_wrap_out", out_a, 0);
    load = 1'b1; load_val = 3'd6;
    tick();
    load = 1'b0;
    check("ldwrap_out", out_a, 6);
    check("ldwrap_tc", tc_a, 0);
    check("ldwrap_uflow", uflow_a, 0);

    // One-shot: load 2, count to DONE.
    T = 1'b0; load = 1'b1; load_val = 3'd2;
    tick();
    load = 1'b0; T = 1'b1;
    check("os_load_out", out_b, 2);
    check("os_load_busy", busy_b, 1);
    tick();
    check("os_out1", out_b, 1);
    tick();
    check("os_out0", out_b, 0);
    check("os_tc_early", tc_b, 0);
    check("os_busy_early", busy_b, 1);
    tick();
    check("os_out_wrap", out_b, 0);
    check("os_tc", tc_b, 1);
    check("os_busy_fall", busy_b, 0);
    check("os_uflow", uflow_b, UF);
    tick();
    check("os_out_hold", out_b, 0);
    check("os_tc_off", tc_b, 0);
    check("os_state", dut_b.state_reg, DONE);

    // T gating on the auto-reload instance.
    T = 1'b0; load = 1'b1; load_val = 3'd7;
    tick();
    load = 1'b0;
    check("gate_out7", out_a, 7);
    T = 1'b1; tick(); check("gate_out6", out_a, 6);
    T = 1'b0; tick(); check("gate_hold6", out_a, 6);
    T = 1'b1; tick(); check("gate_out5", out_a, 5);
    T = 1'b0; tick(); check("gate_hold5", out_a, 5);

    // load_val=0: first T edge produces tc; repeated tc with zero reload.
    load = 1'b1; load_val = 3'd0;
    tick();
    load = 1'b0; T = 1'b1;
    check("zero_out", out_a, 0);
    check("zero_busy", busy_a, 1);
    check("zero_tc_pre", tc_a, 0);
    tick();
    check("zero_tc1", tc_a, 1);
    check("zero_out1", out_a, 0);
    check("zero_os_tc", tc_b, 1);
    check("zero_os_busy", busy_b, 0);
    tick();
    check("zero_tc2", tc_a, 1);
    T = 1'b0;
    tick();
    check("zero_tc_off", tc_a, 0);

    // Reset mid-count aborts without a tc pulse.
    load = 1'b1; load_val = 3'd3;
    tick();
    load = 1'b0; T = 1'b1;
    tick();
    check("mid_out2", out_a, 2);
    tick();
    check("mid_out1", out_a, 1);
    rst = 1'b0;
    tick();
    check("mid_rst_out", out_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_tc", tc_a, 0);
    check("mid_rst_uflow", uflow_a, 0);
    rst = 1'b1;
    tick();
    check("post_rst_out", out_a, 0);
    check("post_rst_tc", tc_a, 0);
    check("post_rst_state", dut_b.state_reg, IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_down_counter.md
SYNC_DOWN_COUNTER -- requirements
Module: sync_down_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3: counter width in bits.
REQ-002 The block SHALL have parameter AUTO_RELOAD, default 1: 1 = reload on wrap, 0 = one-shot.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset, with these ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-low reset.
- T  input  1  count enable; decrements once per clk edge while high.
- load  input  1  parallel-load strobe.
- load_val  input  WIDTH  start/reload value.
- out  output  WIDTH  current count.
- tc  output  1  one-cycle terminal-count pulse.
- busy  output  1  high while counting is armed (RUN).
- uflow  output  1  sticky underflow flag (see Configuration).

Function
REQ-004 The block SHALL be fully synchronous: every register updates only on the rising edge of clk, with no ripple clocking.
REQ-005 The block SHALL have three states:
- IDLE: entered from reset.
- RUN: counting armed.
- DONE: one-shot expired.
REQ-006 Priority on any edge SHALL be: reset, then load, then count.
REQ-007 load=1 in any state SHALL set out=load_val, capture load_val into the reload register, and enter RUN on the next cycle.
REQ-008 In RUN with T=1 and out!=0, the counter SHALL set out=out-1 at the edge.
REQ-009 In RUN with T=1 and out==0, the counter SHALL assert tc for exactly the following cycle, then:
- AUTO_RELOAD=1: set out=reload register and stay in RUN.
- AUTO_RELOAD=0: keep out=0 and enter DONE.
REQ-010 In RUN with T=0, out SHALL hold.
REQ-011 In IDLE and DONE, out SHALL hold and T SHALL be ignored.
REQ-012 busy SHALL be 1 exactly when the state is RUN, and SHALL be registered.
REQ-013 tc SHALL be registered and SHALL never be high for two consecutive cycles unless the reload value is 0 with T held high in auto-reload mode.
REQ-014 load_val=0 SHALL be legal: the first T=1 edge produces tc.
REQ-015 A load on the same edge as the wrap condition SHALL take the load: no tc is asserted, and uflow is not set.
REQ-016 Arithmetic SHALL be unsigned WIDTH-bit, and wrap SHALL be governed only by REQ-009, never by natural modulo underflow.
REQ-017 Latency from load to the first decrement SHALL be 1 cycle: out shows load_val in the cycle after load.

Reset
REQ-018 With rst=0 at a clock edge, the block SHALL set:
- out=0, tc=0, busy=0, uflow=0.
- reload register=0.
- state=IDLE.
REQ-019 Reset asserted mid-count SHALL abort the count with no tc pulse.
REQ-020 Before the first clock edge with rst=0, outputs SHALL be don't-care.

Configuration
REQ-021 Macro SYNC_DOWN_COUNTER_UFLOW_EN SHALL control the sticky underflow flag.
REQ-022 With SYNC_DOWN_COUNTER_UFLOW_EN defined:
- uflow SHALL set on any edge where tc is set.
- uflow SHALL stay set until load=1 or reset.
- If both occur on one edge, load SHALL clear uflow.
REQ-023 With SYNC_DOWN_COUNTER_UFLOW_EN undefined:
- uflow SHALL be constant 0.
- No flag register SHALL exist.
- All other behaviour SHALL be identical.

Structure
REQ-024 Package sync_down_counter_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-025 No sub-module SHALL be used: the block is a single module holding the state register, count register, reload register, tc register, and the optional uflow register.

Verification
REQ-026 Reset: clk period 20, rst=0 for 10 then 1 -> out=0, busy=0, tc=0; T=1 without load leaves out=0.
REQ-027 Auto-reload: load_val=5 with load for 1 cycle, then T=1 -> out sequence 5,4,3,2,1,0,5,4; tc high one cycle, in the cycle out returns to 5.
REQ-028 One-shot (AUTO_RELOAD=0): load_val=2, T=1 -> out 2,1,0,0,0; tc one pulse; busy falls with tc; state DONE.
REQ-029 T gating: load_val=7, T toggled 1,0,1,0 -> out 7,6,6,5,5.
REQ-030 Reset mid-count: load_val=3, two decrements, rst=0 -> out=0, busy=0, no tc pulse.
REQ-031 Underflow (macro defined): wrap once -> uflow=1 and held through further wraps; load_val=4 -> uflow=0 next cycle; load coinciding with the wrap edge -> no tc, uflow stays 0.
